neuro_lif_tile: RTL

- Single leaky integrate-and-fire (LIF) neuron tile.
- Instantiated in an array by the `tt_um_retospect_neurochip` top level. That top level drives the tile's spike inputs from `ui_in`/neighbouring tiles and routes `spike_out` to `uo_out`/`uio_out`.
- Weights, threshold and leak are loaded through a serial configuration chain that daisy-chains tile to tile.
- Membrane integration is gated by a global tick enable.

---
 rtl/neuro_lif_tile.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/neuro_lif_tile.sv
// rtl/neuro_lif_tile.sv - leaky integrate-and-fire neuron tile with serial config chain
// Optional feature macro: NEURO_SPIKE_CNT_EN (adds saturating 16-bit fire counter output spike_cnt)
module neuro_lif_tile #(
   parameter int WIDTH          = 8,
   parameter int N_IN           = 4,
   parameter int W_BITS         = 4,
   parameter int REFRACT_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [N_IN-1:0]  spike_in,
   input  logic             cfg_en,
   input  logic             cfg_data,
   output logic             cfg_out,
   output logic             spike_out,
   output logic [WIDTH-1:0] membrane,
   output logic             refractory
`ifdef NEURO_SPIKE_CNT_EN
   ,
   output logic [15:0]      spike_cnt
`endif
);

   // Config word: weights in the low bits, then 8-bit threshold, then 3-bit leak shift at the top
   localparam int CFG_LEN = N_IN * W_BITS + 8 + 3;
   localparam int T_LSB   = N_IN * W_BITS;
   // Arithmetic headroom so V - leak + sum of weights cannot wrap before saturation
   localparam int SW      = WIDTH + 3;
   localparam int RW      = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [RW-1:0]        REF_LOAD = RW'(REFRACT_CYCLES);

   logic [CFG_LEN-1:0]      r_cfg;
   logic signed [WIDTH-1:0] r_v;
   logic [RW-1:0]           r_ref;
   logic                    r_spike;

   logic [7:0]              w_thresh;
   logic [2:0]              w_leak;
   logic signed [SW-1:0]    w_v_ext;
   logic signed [SW-1:0]    w_leak_amt;
   logic signed [SW-1:0]    w_wsum;
   logic signed [SW-1:0]    w_sum;
   logic signed [SW-1:0]    w_sat;
   logic signed [SW-1:0]    w_thresh_ext;
   logic                    w_fire;
   logic                    w_tick;
   logic                    w_fire_now;

   assign w_thresh     = r_cfg[T_LSB +: 8];
   assign w_leak       = r_cfg[CFG_LEN-1 -: 3];
   assign w_v_ext      = {{(SW-WIDTH){r_v[WIDTH-1]}}, r_v};
   // Threshold is unsigned: zero-extend so values above the positive range can never be reached
   assign w_thresh_ext = {{(SW-8){1'b0}}, w_thresh};

   // Leak, weighted input sum and saturation of the candidate membrane value
   always_comb begin
      w_leak_amt = '0;
      if (w_leak != 3'd0) begin
         w_leak_amt = w_v_ext >>> w_leak;
      end
      w_wsum = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (spike_in[i]) begin
            w_wsum = w_wsum + {{(SW-W_BITS){r_cfg[i*W_BITS+W_BITS-1]}}, r_cfg[i*W_BITS +: W_BITS]};
         end
      end
      w_sum = w_v_ext - w_leak_amt + w_wsum;
      if (w_sum > SAT_MAX) begin
         w_sat = SAT_MAX;
      end else if (w_sum < SAT_MIN) begin
         w_sat = SAT_MIN;
      end else begin
         w_sat = w_sum;
      end
   end

   // Configuration shifting takes priority, so a tick only happens with cfg_en low
   assign w_tick     = ena & ~cfg_en;
   assign w_fire     = (w_thresh != 8'd0) && (w_sat >= w_thresh_ext);
   assign w_fire_now = w_tick && (r_ref == '0) && w_fire;

   // Serial configuration chain, MSB first, advanced only on cfg_en cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg <= '0;
      end else if (cfg_en) begin
         r_cfg <= {r_cfg[CFG_LEN-2:0], cfg_data};
      end
   end

   // Membrane, refractory counter and one-cycle fire pulse, updated on ticks
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v     <= '0;
         r_ref   <= '0;
         r_spike <= 1'b0;
      end else begin
         r_spike <= 1'b0;
         if (w_tick) begin
            if (r_ref != '0) begin
               r_v   <= '0;
               r_ref <= r_ref - RW'(1);
            end else if (w_fire) begin
               r_v     <= '0;
               r_ref   <= REF_LOAD;
               r_spike <= 1'b1;
            end else begin
               r_v <= w_sat[WIDTH-1:0];
            end
         end
      end
   end

`ifdef NEURO_SPIKE_CNT_EN
   logic [15:0] r_spike_cnt;

   // Fire counter, saturating at all-ones, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_spike_cnt <= '0;
      end else if (w_fire_now && (r_spike_cnt != 16'hFFFF)) begin
         r_spike_cnt <= r_spike_cnt + 16'd1;
      end
   end

   assign spike_cnt = r_spike_cnt;
`else
   logic w_unused_fire;
   assign w_unused_fire = w_fire_now;
`endif

   assign cfg_out    = r_cfg[CFG_LEN-1];
   assign spike_out  = r_spike;
   assign membrane   = r_v;
   assign refractory = (r_ref != '0);

endmodule
